issue_scheduler: RTL

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/issue_pkg.sv | 40 ++++
 rtl/issue_hazard_check.sv | 39 +++
 rtl/issue_scheduler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/issue_pkg.sv
// Shared definitions for the dual-issue scheduler: FSM states, RISC-V
// opcode constants, instruction field bounds and the bubble encoding.
package issue_pkg;

    // Scheduler lifecycle: accept fetches, then drain the queue, then idle.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    // Opcodes of the instruction classes that never write a destination register.
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Instruction field bounds (RV32 base encoding).
    localparam int OPC_HI = 6;
    localparam int OPC_LO = 0;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 7;
    localparam int RS1_HI = 19;
    localparam int RS1_LO = 15;
    localparam int RS2_HI = 24;
    localparam int RS2_LO = 20;

    // An all-zero word marks an empty fetch slot and is never queued.
    localparam logic [31:0] NOP = 32'h0;

    // True when the instruction's rd field names a real destination.
    // Stores and branches reuse bits [11:7] as immediate bits, so they
    // are excluded; x0 is hardwired to zero and never creates a dependency.
    function automatic logic writes_reg(input logic [31:0] instr);
        logic [6:0] opc;
        logic [4:0] rd;
        opc = instr[OPC_HI:OPC_LO];
        rd  = instr[RD_HI:RD_LO];
        return (opc != OPC_STORE) && (opc != OPC_BRANCH) && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/issue_hazard_check.sv
// Combinational dependency check between the two queue-head instructions.
// A hazard means the younger word cannot issue alongside the older one.
module issue_hazard_check
    import issue_pkg::*;
(
    input  logic [31:0] older,
    input  logic [31:0] younger,
    output logic        hazard
);

    logic [4:0] older_rd;
    logic [4:0] young_rs1;
    logic [4:0] young_rs2;
    logic [4:0] young_rd;
    logic       older_writes;
    logic       unused_bits;

    assign older_rd  = older[RD_HI:RD_LO];
    assign young_rs1 = younger[RS1_HI:RS1_LO];
    assign young_rs2 = younger[RS2_HI:RS2_LO];
    assign young_rd  = younger[RD_HI:RD_LO];

    assign older_writes = writes_reg(older);

    // Fields that play no part in the dependency decision.
    assign unused_bits = ^{older[31:12], younger[31:25], younger[14:12], younger[6:0]};

    // RAW on either source operand, or WAW on the destination. The compare is
    // deliberately conservative: rs2 is checked even for formats without one.
    always_comb begin
        hazard = 1'b0;
        if (older_writes) begin
            hazard = (older_rd == young_rs1) ||
                     (older_rd == young_rs2) ||
                     (older_rd == young_rd);
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// In-order dual-issue scheduler: fetched instruction pairs are squeezed
// (bubbles dropped) into a circular queue, and each unstalled cycle the
// two oldest entries are presented on registered issue slots, the second
// only when it does not depend on the first.
module issue_scheduler
    import issue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_instr1,
    input  logic [31:0] fetch_instr2,
    input  logic        fetch_finish,
    output logic        fetch_ready,
    input  logic        issue_stall,
    output logic        issue0_valid,
    output logic [31:0] issue0_instr,
    output logic        issue1_valid,
    output logic [31:0] issue1_instr,
    output logic        done
);

    localparam int AW = $clog2(DEPTH);

    // Highest occupancy that still leaves room for a full pair.
    localparam logic [AW:0] FREE_LIMIT = (AW+1)'(DEPTH - 2);
    localparam logic [AW:0] TWO        = (AW+1)'(2);

    logic [31:0]  queue_mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [AW:0]  count;

    sched_state_t state;

    logic         push1;
    logic         push2;
    logic [AW:0]  n_push;
    logic [AW-1:0] wr_idx0;
    logic [AW-1:0] wr_idx1;

    logic [AW-1:0] rd_idx0;
    logic [AW-1:0] rd_idx1;
    logic [31:0]  head;
    logic [31:0]  head_next;
    logic         pair_hazard;
    logic         load0;
    logic         load1;
    logic [AW:0]  n_pop;

    assign count = wptr - rptr;

    // A pair is only taken while running and when both words are guaranteed
    // to fit, independent of how many of them turn out to be bubbles.
    assign fetch_ready = (state == RUN) && (count <= FREE_LIMIT);

    assign push1  = fetch_valid && fetch_ready && (fetch_instr1 != NOP);
    assign push2  = fetch_valid && fetch_ready && (fetch_instr2 != NOP);
    assign n_push = (AW+1)'(push1) + (AW+1)'(push2);

    // The younger word lands directly behind the older one, or in its place
    // when the older word was a bubble.
    assign wr_idx0 = wptr[AW-1:0];
    assign wr_idx1 = push1 ? wr_idx0 + AW'(1) : wr_idx0;

    assign rd_idx0   = rptr[AW-1:0];
    assign rd_idx1   = rd_idx0 + AW'(1);
    assign head      = queue_mem[rd_idx0];
    assign head_next = queue_mem[rd_idx1];

    issue_hazard_check u_hazard (
        .older   (head),
        .younger (head_next),
        .hazard  (pair_hazard)
    );

    // Slot loading decisions use the occupancy before this edge's pushes,
    // so freshly fetched words always spend one cycle in the queue.
    assign load0 = (count != '0);
    assign load1 = (count >= TWO) && !pair_hazard;
    assign n_pop = (AW+1)'(load0) + (AW+1)'(load1);

    // Queue storage write port; contents need no reset because the pointers
    // define which entries are live.
    always_ff @(posedge clk) begin
        if (push1) begin
            queue_mem[wr_idx0] <= fetch_instr1;
        end
        if (push2) begin
            queue_mem[wr_idx1] <= fetch_instr2;
        end
    end

    // Pointers, lifecycle FSM and the registered issue slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            state        <= RUN;
            done         <= 1'b0;
            issue0_valid <= 1'b0;
            issue0_instr <= NOP;
            issue1_valid <= 1'b0;
            issue1_instr <= NOP;
        end else begin
            wptr <= wptr + n_push;

            if ((state == RUN) && fetch_finish) begin
                state <= DRAIN;
            end

            if (!issue_stall) begin
                if (state == DONE) begin
                    issue0_valid <= 1'b0;
                    issue0_instr <= NOP;
                    issue1_valid <= 1'b0;
                    issue1_instr <= NOP;
                end else begin
                    issue0_valid <= load0;
                    issue0_instr <= load0 ? head : NOP;
                    issue1_valid <= load1;
                    issue1_instr <= load1 ? head_next : NOP;
                    rptr         <= rptr + n_pop;

                    // An empty queue loads nothing, so this is the reload
                    // that leaves both slots empty for good.
                    if ((state == DRAIN) && (count == '0)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
